idli_sqi_ctrl_m: RTL and testbench
==================================

# idli_sqi_ctrl_m

SQI memory controller for the idli core. It shares one quad-SPI serial SRAM between two requesters: instruction fetch (read-only) and data (read/write). It arbitrates between them round-robin and sequences each 16-bit access as command, address, dummy and data nibbles on the SQI pins. It drives the core's memory port (sck/cs/io_mode/sio) and replaces the current tie-off values. The SRAM is already in SQI mode when this block leaves reset; the block never issues mode-change commands.

## Interface
- CS_IDLE, 1: extra gck cycles CS is held high after a transaction, before returning to IDLE (≥1).
- RD_CMD, 8'h03: SQI read command byte.
- WR_CMD, 8'h02: SQI write command byte.

Ports:
- i_sqi_gck  in  1  clock; all logic on rising edge.
- i_sqi_rst  in  1  reset, asynchronous, active-high.
- i_sqi_f_vld  in  1  fetch request valid.
- i_sqi_f_addr  in  16  fetch word address.
- o_sqi_f_acp  out  1  fetch request accepted (1-cycle pulse).
- o_sqi_f_rdata  out  16  fetch read data.
- o_sqi_f_rvld  out  1  fetch read data valid (1-cycle pulse).
- i_sqi_d_vld  in  1  data request valid.
- i_sqi_d_wr  in  1  1 = write, 0 = read.
- i_sqi_d_addr  in  16  data address.
- i_sqi_d_wdata  in  16  write data.
- o_sqi_d_acp  out  1  data request accepted (1-cycle pulse).
- o_sqi_d_rdata  out  16  data read data.
- o_sqi_d_rvld  out  1  data read valid (1-cycle pulse; never asserted for writes).
- o_sqi_mem_sck  out  1  SQI clock.
- o_sqi_mem_cs  out  1  chip select, active-low.
- o_sqi_mem_io_mode  out  1  1 = controller drives SIO, 0 = memory drives.
- o_sqi_mem_sio  out  4  nibble out.
- i_sqi_mem_sio  in  4  nibble in.

## Operation
- States: IDLE → CMD (2 nibbles) → ADDR (4) → DUMMY (2, reads only) → DATA (4) → END (CS_IDLE cycles) → IDLE.
- Each nibble takes 2 gck cycles. Phase 0: sck=0; sio out updated at phase entry. Phase 1: sck=1. Input nibble sampled on the gck edge that ends phase 1.
- All fields are MSB nibble first: command byte, address [15:12]..[3:0], data [15:12]..[3:0].
- io_mode=1 in IDLE, CMD, ADDR, write DATA, END. io_mode=0 in DUMMY and read DATA. o_sqi_mem_sio=0 whenever io_mode=0 or CS is high.
- Arbitration happens only in IDLE, registered. If exactly one vld is set, that requester wins. If both are set, the requester not granted last wins. The last-grant pointer resets to "fetch", so the data port wins the first tie. The winner's acp pulses for 1 cycle; addr/wr/wdata are captured in that cycle.
- Requesters hold vld and payload stable until acp; retraction is illegal.
- Read data is shifted into a 16-bit register. The rdata output of the owning port updates, and its rvld pulses, in the cycle after the last nibble is sampled. rdata holds until the next read for that port.
- Reset mid-transaction: CS rises immediately, all outputs return to reset values, no rvld is issued, the arbitration pointer returns to "fetch". The transaction is lost.

## Timing
- Reset values: sck 0, cs 1, io_mode 1, sio 0, both acp 0, both rvld 0, both rdata 0.
- Acp at cycle T. CS is low from T+1.
- Read: CS low T+1..T+24 (CMD 4 + ADDR 8 + DUMMY 4 + DATA 8). rvld at T+25, CS high from T+25.
- Write: CS low T+1..T+20. CS high from T+21.
- CS stays high for CS_IDLE cycles in END, plus 1 IDLE cycle for grant. The minimum CS-high gap between transactions is CS_IDLE+1 cycles.
- Back-to-back: the next acp occurs in the IDLE cycle after END, even while the previous read's rvld is asserted in an earlier cycle.
- sck is 0 whenever CS is high and at CS fall/rise edges.

## Test plan
- Reset, no requests → cs=1, sck=0, io_mode=1, sio=0, no acp for 50 cycles.
- Fetch read addr 16'h1234; memory model returns 16'hBEEF → sio out 0,3,1,2,3,4. io_mode=0 from T+13. o_sqi_f_rdata=16'hBEEF with f_rvld at T+25. d_rvld stays 0.
- Data write addr 16'h00A0, wdata 16'hC0DE → sio nibbles 0,2,0,0,A,0,C,0,D,E. CS high at T+21. No rvld.
- Both vld held from reset, CS_IDLE=1 → grants alternate d,f,d,f. CS-high gap is exactly 2 cycles. Each port's rdata matches its address in the memory model.
- Assert i_sqi_rst during ADDR of a read → cs=1 the same cycle (async). Released → no rvld. The next tie is granted to data.

Source files
------------

// File: rtl/idli_sqi_ctrl_m.sv
// idli_sqi_ctrl_m
// SQI memory controller shared by the instruction-fetch and data requesters.
// Arbitrates round-robin between the two ports and sequences each 16-bit
// access on the quad-SPI pins as command, address, dummy (reads) and data
// nibbles, MSB nibble first. The SRAM is assumed to be in SQI mode already.
//
// Ports:
//   i_sqi_gck / i_sqi_rst           clock, async active-high reset
//   i_sqi_f_* / o_sqi_f_*           fetch port: vld/addr in, acp/rdata/rvld out
//   i_sqi_d_* / o_sqi_d_*           data port: vld/wr/addr/wdata in, acp/rdata/rvld out
//   o_sqi_mem_sck/cs/io_mode/sio    SQI pins towards the SRAM (all registered)
//   i_sqi_mem_sio                   nibble driven by the SRAM
module idli_sqi_ctrl_m #(
  parameter int unsigned CS_IDLE = 1,
  parameter logic [7:0]  RD_CMD  = 8'h03,
  parameter logic [7:0]  WR_CMD  = 8'h02
) (
  input  logic        i_sqi_gck,
  input  logic        i_sqi_rst,
  input  logic        i_sqi_f_vld,
  input  logic [15:0] i_sqi_f_addr,
  output logic        o_sqi_f_acp,
  output logic [15:0] o_sqi_f_rdata,
  output logic        o_sqi_f_rvld,
  input  logic        i_sqi_d_vld,
  input  logic        i_sqi_d_wr,
  input  logic [15:0] i_sqi_d_addr,
  input  logic [15:0] i_sqi_d_wdata,
  output logic        o_sqi_d_acp,
  output logic [15:0] o_sqi_d_rdata,
  output logic        o_sqi_d_rvld,
  output logic        o_sqi_mem_sck,
  output logic        o_sqi_mem_cs,
  output logic        o_sqi_mem_io_mode,
  output logic [3:0]  o_sqi_mem_sio,
  input  logic [3:0]  i_sqi_mem_sio
);

  typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA, ST_END} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;        // cycle within state; [0] = phase, [2:1] = nibble
  logic [15:0] addr_q, addr_d;
  logic        wr_q, wr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        own_d_q, own_d_d;    // 1 = current transaction belongs to the data port
  logic        last_f_q, last_f_d;  // 1 = fetch was granted last
  logic [11:0] shift_q, shift_d;
  logic        f_acp_q, f_acp_d, d_acp_q, d_acp_d;
  logic [15:0] f_rdata_q, f_rdata_d, d_rdata_q, d_rdata_d;
  logic        f_rvld_q, f_rvld_d, d_rvld_q, d_rvld_d;
  logic        sck_q, sck_d, cs_q, cs_d, io_mode_q, io_mode_d;
  logic [3:0]  sio_q, sio_d;
  logic        arb_s, active_s;
  logic [7:0]  cmd_s;

  function automatic logic [3:0] nib_sel(input logic [15:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    nib_sel = w[15:12];
      2'd1:    nib_sel = w[11:8];
      2'd2:    nib_sel = w[7:4];
      default: nib_sel = w[3:0];
    endcase
  endfunction

  // Next-state, arbitration, read shifting and pin values for the next cycle
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 8'd1;
    addr_d    = addr_q;
    wr_d      = wr_q;
    wdata_d   = wdata_q;
    own_d_d   = own_d_q;
    last_f_d  = last_f_q;
    shift_d   = shift_q;
    f_acp_d   = 1'b0;
    d_acp_d   = 1'b0;
    f_rdata_d = f_rdata_q;
    d_rdata_d = d_rdata_q;
    f_rvld_d  = 1'b0;
    d_rvld_d  = 1'b0;
    arb_s     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = 8'd0;
        // The acp cycle itself is spent in IDLE; the transaction starts after it.
        if (f_acp_q || d_acp_q) begin
          state_d = ST_CMD;
        end else begin
          arb_s = 1'b1;
        end
      end
      ST_CMD: begin
        if (cnt_q == 8'd3) begin
          state_d = ST_ADDR;
          cnt_d   = 8'd0;
        end
      end
      ST_ADDR: begin
        if (cnt_q == 8'd7) begin
          state_d = wr_q ? ST_DATA : ST_DUMMY;
          cnt_d   = 8'd0;
        end
      end
      ST_DUMMY: begin
        if (cnt_q == 8'd3) begin
          state_d = ST_DATA;
          cnt_d   = 8'd0;
        end
      end
      ST_DATA: begin
        // Memory nibble is taken on the edge that ends phase 1.
        if (!wr_q && cnt_q[0]) begin
          shift_d = {shift_q[7:0], i_sqi_mem_sio};
        end
        if (cnt_q == 8'd7) begin
          state_d = ST_END;
          cnt_d   = 8'd0;
          if (!wr_q) begin
            if (own_d_q) begin
              d_rdata_d = {shift_q, i_sqi_mem_sio};
              d_rvld_d  = 1'b1;
            end else begin
              f_rdata_d = {shift_q, i_sqi_mem_sio};
              f_rvld_d  = 1'b1;
            end
          end
        end
      end
      ST_END: begin
        // Grant on the way out so acp lands in the single IDLE cycle that follows.
        if (cnt_q == 8'(CS_IDLE - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
          arb_s   = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase

    // Round-robin: on a tie the port not granted last wins.
    if (arb_s) begin
      if (i_sqi_d_vld && (!i_sqi_f_vld || last_f_q)) begin
        d_acp_d  = 1'b1;
        own_d_d  = 1'b1;
        last_f_d = 1'b0;
        addr_d   = i_sqi_d_addr;
        wr_d     = i_sqi_d_wr;
        wdata_d  = i_sqi_d_wdata;
      end else if (i_sqi_f_vld) begin
        f_acp_d  = 1'b1;
        own_d_d  = 1'b0;
        last_f_d = 1'b1;
        addr_d   = i_sqi_f_addr;
        wr_d     = 1'b0;
      end else begin
        own_d_d  = own_d_q;
      end
    end else begin
      own_d_d = own_d_q;
    end

    // Pins are a pure function of the next state so they stay glitch-free flops.
    active_s  = (state_d == ST_CMD) || (state_d == ST_ADDR) ||
                (state_d == ST_DUMMY) || (state_d == ST_DATA);
    cmd_s     = wr_d ? WR_CMD : RD_CMD;
    cs_d      = !active_s;
    sck_d     = active_s && cnt_d[0];
    io_mode_d = !((state_d == ST_DUMMY) || ((state_d == ST_DATA) && !wr_d));
    case (state_d)
      ST_CMD:  sio_d = cnt_d[1] ? cmd_s[3:0] : cmd_s[7:4];
      ST_ADDR: sio_d = nib_sel(addr_d, cnt_d[2:1]);
      ST_DATA: sio_d = wr_d ? nib_sel(wdata_d, cnt_d[2:1]) : 4'h0;
      default: sio_d = 4'h0;
    endcase
  end

  // State, captured request and registered outputs
  always_ff @(posedge i_sqi_gck or posedge i_sqi_rst) begin
    if (i_sqi_rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      addr_q    <= 16'h0000;
      wr_q      <= 1'b0;
      wdata_q   <= 16'h0000;
      own_d_q   <= 1'b0;
      last_f_q  <= 1'b1;
      shift_q   <= 12'h000;
      f_acp_q   <= 1'b0;
      d_acp_q   <= 1'b0;
      f_rdata_q <= 16'h0000;
      d_rdata_q <= 16'h0000;
      f_rvld_q  <= 1'b0;
      d_rvld_q  <= 1'b0;
      sck_q     <= 1'b0;
      cs_q      <= 1'b1;
      io_mode_q <= 1'b1;
      sio_q     <= 4'h0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      own_d_q   <= own_d_d;
      last_f_q  <= last_f_d;
      shift_q   <= shift_d;
      f_acp_q   <= f_acp_d;
      d_acp_q   <= d_acp_d;
      f_rdata_q <= f_rdata_d;
      d_rdata_q <= d_rdata_d;
      f_rvld_q  <= f_rvld_d;
      d_rvld_q  <= d_rvld_d;
      sck_q     <= sck_d;
      cs_q      <= cs_d;
      io_mode_q <= io_mode_d;
      sio_q     <= sio_d;
    end
  end

  assign o_sqi_f_acp       = f_acp_q;
  assign o_sqi_f_rdata     = f_rdata_q;
  assign o_sqi_f_rvld      = f_rvld_q;
  assign o_sqi_d_acp       = d_acp_q;
  assign o_sqi_d_rdata     = d_rdata_q;
  assign o_sqi_d_rvld      = d_rvld_q;
  assign o_sqi_mem_sck     = sck_q;
  assign o_sqi_mem_cs      = cs_q;
  assign o_sqi_mem_io_mode = io_mode_q;
  assign o_sqi_mem_sio     = sio_q;

endmodule

// File: tb/tb_idli_sqi_ctrl_m.sv
// Testbench for idli_sqi_ctrl_m: SQI SRAM pin model, scoreboard of expected
// read data per port, and one task per scenario with cycle-exact pin checks.
module tb_idli_sqi_ctrl_m;
  localparam int CS_IDLE = 1;

  logic        gck = 1'b0;
  logic        rst = 1'b1;
  logic        f_vld = 1'b0, d_vld = 1'b0, d_wr = 1'b0;
  logic [15:0] f_addr = 16'h0, d_addr = 16'h0, d_wdata = 16'h0;
  logic        f_acp, d_acp, f_rvld, d_rvld;
  logic [15:0] f_rdata, d_rdata;
  logic        sck, cs, io_mode;
  logic [3:0]  sio_out;
  logic [3:0]  sio_in = 4'h0;

  int checks = 0;
  int errors = 0;

  logic [15:0] sram    [0:65535];
  logic [15:0] ref_mem [0:65535];
  logic [15:0] sb_f[$];
  logic [15:0] sb_d[$];

  int          nib_cnt = 0;
  logic [7:0]  m_cmd = 8'h00;
  logic [15:0] m_addr = 16'h0, m_wd = 16'h0, m_word;

  idli_sqi_ctrl_m #(.CS_IDLE(CS_IDLE), .RD_CMD(8'h03), .WR_CMD(8'h02)) dut (
    .i_sqi_gck(gck), .i_sqi_rst(rst),
    .i_sqi_f_vld(f_vld), .i_sqi_f_addr(f_addr), .o_sqi_f_acp(f_acp),
    .o_sqi_f_rdata(f_rdata), .o_sqi_f_rvld(f_rvld),
    .i_sqi_d_vld(d_vld), .i_sqi_d_wr(d_wr), .i_sqi_d_addr(d_addr),
    .i_sqi_d_wdata(d_wdata), .o_sqi_d_acp(d_acp), .o_sqi_d_rdata(d_rdata),
    .o_sqi_d_rvld(d_rvld),
    .o_sqi_mem_sck(sck), .o_sqi_mem_cs(cs), .o_sqi_mem_io_mode(io_mode),
    .o_sqi_mem_sio(sio_out), .i_sqi_mem_sio(sio_in)
  );

  always #5 gck = ~gck;

  // SQI SRAM model: decodes cmd/addr from the pins, serves reads, commits writes
  always @(negedge gck) begin
    if (cs) begin
      nib_cnt = 0;
      sio_in  = 4'h0;
    end else if (sck) begin
      if (nib_cnt < 2) m_cmd = {m_cmd[3:0], sio_out};
      else if (nib_cnt < 6) m_addr = {m_addr[11:0], sio_out};
      if (m_cmd == 8'h03 && nib_cnt >= 8 && nib_cnt < 12) begin
        m_word = sram[m_addr];
        sio_in = m_word[4*(11-nib_cnt) +: 4];
      end
      if (m_cmd == 8'h02 && nib_cnt >= 6 && nib_cnt < 10) begin
        m_wd = {m_wd[11:0], sio_out};
        if (nib_cnt == 9) sram[m_addr] = m_wd;
      end
      nib_cnt++;
    end
  end

  // Scoreboard: push expected data on acp, pop and compare on rvld
  always @(negedge gck) begin
    if (f_acp) sb_f.push_back(ref_mem[f_addr]);
    if (d_acp) begin
      if (d_wr) ref_mem[d_addr] = d_wdata;
      else      sb_d.push_back(ref_mem[d_addr]);
    end
    if (f_rvld) begin
      checks++;
      if (sb_f.size() == 0) begin
        errors++;
        $display("FAIL sb_f_unexpected_rvld got=%h expected=no rvld", f_rdata);
      end else if (f_rdata !== sb_f[0]) begin
        errors++;
        $display("FAIL sb_f_rdata got=%h expected=%h", f_rdata, sb_f[0]);
      end
      if (sb_f.size() != 0) void'(sb_f.pop_front());
    end
    if (d_rvld) begin
      checks++;
      if (sb_d.size() == 0) begin
        errors++;
        $display("FAIL sb_d_unexpected_rvld got=%h expected=no rvld", d_rdata);
      end else if (d_rdata !== sb_d[0]) begin
        errors++;
        $display("FAIL sb_d_rdata got=%h expected=%h", d_rdata, sb_d[0]);
      end
      if (sb_d.size() != 0) void'(sb_d.pop_front());
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    f_vld = 1'b0;
    d_vld = 1'b0;
    repeat (3) @(negedge gck);
    rst = 1'b0;
    sb_f.delete();
    sb_d.delete();
  endtask

  // Present a request and wait (bounded) for its acp; returns 1 cycle T's negedge+1
  task automatic issue(input logic is_d, input logic wr, input logic [15:0] addr,
                       input logic [15:0] wdata);
    logic got;
    got = 1'b0;
    if (is_d) begin
      d_vld = 1'b1; d_wr = wr; d_addr = addr; d_wdata = wdata;
    end else begin
      f_vld = 1'b1; f_addr = addr;
    end
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge gck);
      got = is_d ? d_acp : f_acp;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL issue_acp_timeout got=no acp expected=acp within 100 cycles");
    end
    #1;
    f_vld = 1'b0;
    d_vld = 1'b0;
  endtask

  // Cycle-exact check of pins and rvld for the transaction acked in the last cycle
  task automatic check_txn(input logic is_d, input logic wr, input logic [15:0] addr,
                           input logic [15:0] wdata, input logic [15:0] exp_rdata,
                           input string name);
    logic [3:0] nibs [10];
    logic [7:0] cmd;
    int         len;
    logic       e_cs, e_sck, e_io, e_fr, e_dr;
    logic [3:0] e_sio;
    cmd = wr ? 8'h02 : 8'h03;
    nibs[0] = cmd[7:4];    nibs[1] = cmd[3:0];
    nibs[2] = addr[15:12]; nibs[3] = addr[11:8]; nibs[4] = addr[7:4]; nibs[5] = addr[3:0];
    nibs[6] = wdata[15:12]; nibs[7] = wdata[11:8]; nibs[8] = wdata[7:4]; nibs[9] = wdata[3:0];
    len = wr ? 20 : 24;
    for (int k = 1; k <= len + 2; k++) begin
      @(negedge gck);
      e_cs  = (k > len);
      e_sck = (k <= len) && (k % 2 == 0);
      e_io  = wr || (k <= 12) || (k > len);
      e_sio = (!e_cs && e_io) ? nibs[(k-1)/2] : 4'h0;
      e_fr  = !wr && !is_d && (k == 25);
      e_dr  = !wr && is_d && (k == 25);
      checks++;
      if ({cs, sck, io_mode, sio_out, f_rvld, d_rvld} !== {e_cs, e_sck, e_io, e_sio, e_fr, e_dr}) begin
        errors++;
        $display("FAIL %s_pins k=%0d got cs=%b sck=%b io=%b sio=%h frv=%b drv=%b expected cs=%b sck=%b io=%b sio=%h frv=%b drv=%b",
                 name, k, cs, sck, io_mode, sio_out, f_rvld, d_rvld, e_cs, e_sck, e_io, e_sio, e_fr, e_dr);
      end
      if (k == 25) begin
        checks++;
        if ((is_d ? d_rdata : f_rdata) !== exp_rdata) begin
          errors++;
          $display("FAIL %s_rdata got=%h expected=%h", name, is_d ? d_rdata : f_rdata, exp_rdata);
        end
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 50; i++) begin
      @(negedge gck);
      checks++;
      if ({cs, sck, io_mode, sio_out, f_acp, d_acp, f_rvld, d_rvld} !== {1'b1, 1'b0, 1'b1, 4'h0, 4'b0000}) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got cs=%b sck=%b io=%b sio=%h acp=%b%b rvld=%b%b expected cs=1 sck=0 io=1 sio=0 acp=00 rvld=00",
                 i, cs, sck, io_mode, sio_out, f_acp, d_acp, f_rvld, d_rvld);
      end
    end
    checks++;
    if ({f_rdata, d_rdata} !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata got=%h/%h expected=0000/0000", f_rdata, d_rdata);
    end
  endtask

  task automatic test_fetch_read();
    issue(1'b0, 1'b0, 16'h1234, 16'h0000);
    check_txn(1'b0, 1'b0, 16'h1234, 16'h0000, 16'hBEEF, "fetch_read");
  endtask

  task automatic test_data_write();
    issue(1'b1, 1'b1, 16'h00A0, 16'hC0DE);
    check_txn(1'b1, 1'b1, 16'h00A0, 16'hC0DE, 16'h0000, "data_write");
    checks++;
    if (sram[16'h00A0] !== 16'hC0DE) begin
      errors++;
      $display("FAIL data_write_mem got=%h expected=c0de", sram[16'h00A0]);
    end
  endtask

  task automatic test_data_read();
    issue(1'b1, 1'b0, 16'h00A0, 16'h0000);
    check_txn(1'b1, 1'b0, 16'h00A0, 16'h0000, 16'hC0DE, "data_read");
  endtask

  task automatic test_back_to_back();
    logic grants [4];
    int   gaps   [3];
    int   ng, ngap, run, fi, di;
    logic seen_low;
    ng = 0; ngap = 0; run = 0; fi = 0; di = 0; seen_low = 1'b0;
    do_reset();
    #1;
    f_addr = 16'h0100; d_addr = 16'h0200; d_wr = 1'b0;
    f_vld = 1'b1; d_vld = 1'b1;
    for (int c = 0; c < 400 && (ng < 4 || ngap < 3); c++) begin
      @(negedge gck);
      if (cs == 1'b0) begin
        if (seen_low && run > 0 && ngap < 3) begin
          gaps[ngap] = run;
          ngap++;
        end
        seen_low = 1'b1;
        run = 0;
      end else begin
        run++;
      end
      if (d_acp && ng < 4) begin grants[ng] = 1'b1; ng++; di++; end
      if (f_acp && ng < 4) begin grants[ng] = 1'b0; ng++; fi++; end
      #1;
      f_addr = 16'h0100 + 16'(fi);
      d_addr = 16'h0200 + 16'(di);
      if (ng >= 4) begin f_vld = 1'b0; d_vld = 1'b0; end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= ng || grants[i] !== ((i % 2) == 0)) begin
        errors++;
        $display("FAIL b2b_grant idx=%0d got=%s expected=%s", i,
                 (i >= ng) ? "none" : (grants[i] ? "d" : "f"), ((i % 2) == 0) ? "d" : "f");
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= ngap || gaps[i] != CS_IDLE + 1) begin
        errors++;
        $display("FAIL b2b_cs_gap idx=%0d got=%0d expected=%0d", i, (i >= ngap) ? -1 : gaps[i], CS_IDLE + 1);
      end
    end
    repeat (40) @(negedge gck);
    checks++;
    if (sb_f.size() != 0 || sb_d.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain got pending f=%0d d=%0d expected=0 0", sb_f.size(), sb_d.size());
    end
  endtask

  task automatic test_reset_mid();
    logic bad, got, won_d;
    issue(1'b0, 1'b0, 16'h0300, 16'h0000);
    repeat (7) @(negedge gck);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({cs, sck, io_mode, sio_out} !== {1'b1, 1'b0, 1'b1, 4'h0}) begin
      errors++;
      $display("FAIL rst_mid_async got cs=%b sck=%b io=%b sio=%h expected cs=1 sck=0 io=1 sio=0",
               cs, sck, io_mode, sio_out);
    end
    repeat (2) @(negedge gck);
    rst = 1'b0;
    sb_f.delete();
    sb_d.delete();
    bad = 1'b0;
    repeat (40) begin
      @(negedge gck);
      if (f_rvld || d_rvld || !cs) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL rst_mid_quiet got=activity after reset expected=no rvld and cs high");
    end
    #1;
    f_addr = 16'h0400; d_addr = 16'h0500; d_wr = 1'b0;
    f_vld = 1'b1; d_vld = 1'b1;
    got = 1'b0; won_d = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge gck);
      if (f_acp || d_acp) begin got = 1'b1; won_d = d_acp; end
    end
    #1;
    f_vld = 1'b0; d_vld = 1'b0;
    checks++;
    if (!got || !won_d) begin
      errors++;
      $display("FAIL rst_mid_tie got=%s expected=d", got ? "f" : "none");
    end
    repeat (40) @(negedge gck);
    checks++;
    if (sb_f.size() != 0 || sb_d.size() != 0) begin
      errors++;
      $display("FAIL rst_mid_drain got pending f=%0d d=%0d expected=0 0", sb_f.size(), sb_d.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      sram[i]    = 16'(i) ^ 16'h5A5A;
      ref_mem[i] = 16'(i) ^ 16'h5A5A;
    end
    sram[16'h1234]    = 16'hBEEF;
    ref_mem[16'h1234] = 16'hBEEF;
    test_reset();
    test_fetch_read();
    test_data_write();
    test_data_read();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
